// File: rtl/uart_pkg.sv
// Shared UART definitions: baud rate table, per-baud bit-period constant and FSM state encoding.
// Used by uart_tx here and by uart_rx elsewhere.
package uart_pkg;

  localparam int unsigned BAUD_TABLE [8] = '{
    9600, 19200, 38400, 57600, 115200, 230400, 460800, 921600
  };

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  // NCLK is the terminal count of the divisor, so a bit lasts NCLK+1 clocks.
  function automatic logic [15:0] nclk_of(input int unsigned clk_mhz,
                                          input logic [2:0]  baud_sel);
    int unsigned period;
    period = (32'd1000000 * clk_mhz) / BAUD_TABLE[baud_sel];
    return 16'(period - 32'd1);
  endfunction

endpackage

// File: rtl/tx_bps_gen.sv
// Bit-period generator for uart_tx: latches the baud select on load and emits a
// one-cycle bit_tick on the last clock of every bit while enabled.
module tx_bps_gen
  import uart_pkg::*;
#(
  parameter int unsigned UART_CLK_MHZ = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [2:0] baud_sel,
  input  logic       enable,
  output logic       bit_tick
);

  // All eight terminal counts are elaboration-time constants, so no divider is built.
  localparam logic [15:0] NCLK_TAB [8] = '{
    nclk_of(UART_CLK_MHZ, 3'd0), nclk_of(UART_CLK_MHZ, 3'd1),
    nclk_of(UART_CLK_MHZ, 3'd2), nclk_of(UART_CLK_MHZ, 3'd3),
    nclk_of(UART_CLK_MHZ, 3'd4), nclk_of(UART_CLK_MHZ, 3'd5),
    nclk_of(UART_CLK_MHZ, 3'd6), nclk_of(UART_CLK_MHZ, 3'd7)
  };

  logic [2:0]  baud_q;
  logic [15:0] cnt_q;
  logic [15:0] nclk;

  assign nclk     = NCLK_TAB[baud_q];
  assign bit_tick = enable && (cnt_q == nclk);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_q <= 3'd0;
    end else if (load) begin
      baud_q <= baud_sel;
    end
  end

  // The counter sits at zero while idle so the first bit of a frame gets a full period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 16'd0;
    end else if (!enable || bit_tick) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8N1 frames, LSB first, with selectable baud rate.
// Define UART_TX_PARITY_EN to add an even parity bit (8E1, 11-bit frame).
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned UART_CLK_MHZ = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] baud_sel_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       rs232_tx_data_o,
  output logic       tx_busy_o,
  output logic       rs232_tx_int
);

  uart_state_t state_q, state_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  data_q;
  logic        line_q, line_d;
  logic        accept;
  logic        bit_tick;

  assign accept          = tx_valid_i && (state_q == IDLE);
  assign tx_ready_o      = (state_q == IDLE);
  assign tx_busy_o       = !tx_ready_o;
  assign rs232_tx_data_o = line_q;
  assign rs232_tx_int    = (state_q == STOP) && bit_tick;

  tx_bps_gen #(
    .UART_CLK_MHZ (UART_CLK_MHZ)
  ) u_bps_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .baud_sel (baud_sel_i),
    .enable   (state_q != IDLE),
    .bit_tick (bit_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_idx_q <= 3'd0;
      data_q    <= 8'd0;
      line_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      line_q    <= line_d;
      if (accept) begin
        data_q <= tx_data_i;
      end
    end
  end

  // The serial line is registered from the next state so it never glitches.
  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    line_d    = 1'b1;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = START;
        end
      end
      START: begin
        if (bit_tick) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_tick) begin
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_tick) begin
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_tick) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    case (state_d)
      START:   line_d = 1'b0;
      DATA:    line_d = data_q[bit_idx_d];
`ifdef UART_TX_PARITY_EN
      PARITY:  line_d = ^data_q;
`endif
      default: line_d = 1'b1;
    endcase
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter UART_CLK_MHZ, default 50, meaning the clk frequency in MHz.
REQ-002 SHALL have port clk  input  1  system clock; one clock domain only, all logic on posedge clk.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port baud_sel_i  input  3  baud select: 0=9600, 1=19200, 2=38400, 3=57600, 4=115200, 5=230400, 6=460800, 7=921600.
REQ-005 SHALL have port tx_data_i  input  8  byte to transmit.
REQ-006 SHALL have port tx_valid_i  input  1  byte request, held until accepted.
REQ-007 SHALL have port tx_ready_o  output  1  block can accept a byte.
REQ-008 SHALL have port rs232_tx_data_o  output  1  serial line out, idle high.
REQ-009 SHALL have port tx_busy_o  output  1  frame in progress.
REQ-010 SHALL have port rs232_tx_int  output  1  one-cycle pulse at frame end.

Function
REQ-011 SHALL use a state machine with states IDLE, START, DATA, PARITY and STOP; PARITY exists only under REQ-027.
REQ-012 SHALL drive tx_ready_o=1 only in IDLE, and SHALL drive tx_busy_o = !tx_ready_o.
REQ-013 SHALL accept a byte on the cycle where tx_valid_i && tx_ready_o, latching tx_data_i and baud_sel_i in that same cycle.
REQ-014 SHALL ignore changes on tx_data_i and baud_sel_i after acceptance until the next acceptance.
REQ-015 SHALL start driving the start bit (0) on the cycle after acceptance (latency 1).
REQ-016 SHALL hold every bit for exactly NCLK+1 clk cycles, where NCLK = 1000000*UART_CLK_MHZ/baud - 1 (integer division).
REQ-017 SHALL hold the divisor counter at 16 bits, counting from 0 to NCLK and then wrapping to 0 while advancing to the next bit.
REQ-018 SHALL send 8 data bits LSB first, using a 3-bit bit index that wraps 7->0 on the DATA exit.
REQ-019 SHALL send one stop bit (1), then return to IDLE.
REQ-020 SHALL pulse rs232_tx_int high for exactly one cycle, on the last clk cycle of the stop bit.
REQ-021 SHALL enter IDLE, with tx_ready_o=1, on the cycle after that last stop-bit cycle.
REQ-022 SHALL give back-to-back bytes (tx_valid_i held high) exactly one idle-high clk cycle between frames, i.e. a stop bit of effectively NCLK+2 cycles.
REQ-023 SHALL ignore tx_valid_i while busy: no queuing, no corruption of the current frame.

Reset
REQ-024 SHALL force the following asynchronously on rst_n=0: rs232_tx_data_o=1, tx_ready_o=1, tx_busy_o=0, rs232_tx_int=0, state=IDLE, counters=0, latched byte=0, latched baud_sel=0.
REQ-025 SHALL abort any frame when reset occurs mid-frame, with the line high immediately and no rs232_tx_int pulse.
REQ-026 SHALL be able to accept a byte on the first clk edge after rst_n deasserts.

Configuration
REQ-027 SHALL, with UART_TX_PARITY_EN defined, insert a PARITY state between DATA and STOP that sends even parity (XOR of the 8 data bits) for NCLK+1 cycles, giving an 11-bit frame.
REQ-028 SHALL, without UART_TX_PARITY_EN, go directly from DATA to STOP, giving a 10-bit frame, and SHALL contain no parity logic.

Structure
REQ-029 SHALL take the baud rate table, the per-baud NCLK constant function and the state encoding from a shared package uart_pkg, which uart_rx will also use.
REQ-030 SHALL place baud selection and the bit-period tick in one sub-module, tx_bps_gen, which emits a one-cycle bit_tick when the count reaches NCLK.
REQ-031 SHALL keep the FSM and shift register in uart_tx.

Verification (UART_CLK_MHZ=50)
REQ-032 SHALL cover: baud_sel_i=4, byte 0x55 -> line 0,1,0,1,0,1,0,1,0,1, each bit 434 clk; rs232_tx_int pulses 4340 clk after the start bit begins.
REQ-033 SHALL cover: baud_sel_i=0, byte 0xA3 -> bits 0,1,1,0,0,0,1,0,1,1 at 5208 clk per bit; tx_ready_o low throughout the frame.
REQ-034 SHALL cover: tx_valid_i held high with bytes 0x01 then 0x80 at baud_sel_i=7 (54 clk/bit) -> exactly 1 idle-high cycle between the stop bit and the second start bit, both bytes correct.
REQ-035 SHALL cover: tx_data_i and baud_sel_i changed mid-frame -> the frame still carries the originally latched byte and baud rate.
REQ-036 SHALL cover: rst_n pulsed low during data bit 3 -> line high immediately, no rs232_tx_int, and the next byte is sent correctly.
REQ-037 SHALL cover, with UART_TX_PARITY_EN: byte 0x07 -> parity bit 1 and an 11-bit frame; byte 0x03 -> parity bit 0.
